// File: rtl/i2c_init_seq.sv
// rtl/i2c_init_seq.sv - table-driven I2C register init sequencer for i2c_core
module i2c_init_seq #(
   parameter logic [6:0] DEV_ADDR   = 7'h36,
   parameter int          TBL_AW     = 6,
   parameter int          DELAY_UNIT = 27000,
   parameter int          RQT_HOLD   = 4,
   parameter int          GAP_CYCLES = 64,
   parameter int          TIMEOUT    = 2000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [17:0]       tbl_data,
   output logic              i2c_rqt,
   output logic              cmd,
   output logic [6:0]        addr_dev,
   output logic [7:0]        addr_reg_L,
   output logic [7:0]        data_wr_L,
   input  logic [7:0]        data_rd,
   input  logic              data_rdy,
   input  logic              error,
   input  logic              i2c_done,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [TBL_AW-1:0] fail_idx,
   output logic              mismatch,
   output logic [7:0]        rd_last
);

   // Counter widths sized for the worst-case load of each counter.
   localparam int DLY_W  = $clog2(255 * DELAY_UNIT + 1);
   localparam int WD_W   = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(RQT_HOLD + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   // Table entry opcodes.
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;

   // Sequencer states.
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_REQ     = 4'd3;
   localparam logic [3:0] S_WAIT    = 4'd4;
   localparam logic [3:0] S_DRAIN   = 4'd5;
   localparam logic [3:0] S_DELAY   = 4'd6;
   localparam logic [3:0] S_ADVANCE = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;
   localparam logic [3:0] S_FAIL    = 4'd9;

   logic [3:0]        state;
   logic              cmd_q;
   logic [7:0]        reg_q;
   logic [7:0]        val_q;
   logic              done_q;
   logic              done_rise;
   logic              dec_xfer;
   logic [1:0]        op;
   logic [HOLD_W-1:0] hold_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DLY_W-1:0]  dly_cnt;

   assign op        = tbl_data[17:16];
   assign done_rise = i2c_done && !done_q;

   // While decoding a transfer entry, present its fields straight from the
   // table so cmd/reg/data are settled a full cycle before i2c_rqt rises;
   // afterwards the latched copies hold them until the next decode.
   assign dec_xfer   = (state == S_DECODE) && !op[1];
   assign cmd        = dec_xfer ? (op == OP_WRITE) : cmd_q;
   assign addr_reg_L = dec_xfer ? tbl_data[15:8]   : reg_q;
   assign data_wr_L  = dec_xfer ? tbl_data[7:0]    : val_q;
   assign addr_dev   = DEV_ADDR;

   assign busy = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);

   // Registered copy of i2c_done for rising-edge detection in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= i2c_done;
      end
   end

   // Main sequencer: table walk, request handshake, watchdog, gaps and delays.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tbl_addr <= '0;
         i2c_rqt  <= 1'b0;
         cmd_q    <= 1'b1;
         reg_q    <= 8'h00;
         val_q    <= 8'h00;
         done     <= 1'b0;
         fail     <= 1'b0;
         fail_idx <= '0;
         mismatch <= 1'b0;
         rd_last  <= 8'h00;
         hold_cnt <= '0;
         wd_cnt   <= '0;
         gap_cnt  <= '0;
         dly_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start) begin
                  state    <= S_FETCH;
                  tbl_addr <= '0;
                  done     <= 1'b0;
                  fail     <= 1'b0;
                  mismatch <= 1'b0;
                  fail_idx <= '0;
               end
            end

            // One cycle for the synchronous table ROM to present the entry.
            S_FETCH: begin
               state <= S_DECODE;
            end

            S_DECODE: begin
               case (op)
                  OP_WRITE, OP_READ: begin
                     cmd_q    <= (op == OP_WRITE);
                     reg_q    <= tbl_data[15:8];
                     val_q    <= tbl_data[7:0];
                     i2c_rqt  <= 1'b1;
                     hold_cnt <= '0;
                     wd_cnt   <= '0;
                     state    <= S_REQ;
                  end
                  OP_DELAY: begin
                     dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
                     state   <= S_DELAY;
                  end
                  default: begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               endcase
            end

            // Hold the request long enough for the core's edge detector.
            // The watchdog already runs here so it measures from the request.
            S_REQ: begin
               wd_cnt <= wd_cnt + WD_W'(1);
               if (hold_cnt == HOLD_W'(RQT_HOLD - 1)) begin
                  i2c_rqt <= 1'b0;
                  state   <= S_WAIT;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            S_WAIT: begin
               if (data_rdy && !cmd_q) begin
                  rd_last <= data_rd;
                  if (data_rd != val_q) begin
                     mismatch <= 1'b1;
                  end
               end
               if (done_rise) begin
                  if (error) begin
                     fail     <= 1'b1;
                     fail_idx <= tbl_addr;
                     state    <= S_FAIL;
                  end else begin
                     gap_cnt <= '0;
                     state   <= S_DRAIN;
                  end
               end else if (wd_cnt >= WD_W'(TIMEOUT)) begin
                  fail     <= 1'b1;
                  fail_idx <= tbl_addr;
                  state    <= S_FAIL;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end

            // The gap only counts cycles with i2c_done already low.
            S_DRAIN: begin
               if (i2c_done) begin
                  gap_cnt <= '0;
               end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state <= S_ADVANCE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            // Counts down from N*DELAY_UNIT to zero inclusive.
            S_DELAY: begin
               if (dly_cnt == '0) begin
                  state <= S_ADVANCE;
               end else begin
                  dly_cnt <= dly_cnt - DLY_W'(1);
               end
            end

            // The last table slot acts as an implicit END; the address never wraps.
            S_ADVANCE: begin
               if (&tbl_addr) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tbl_addr <= tbl_addr + TBL_AW'(1);
                  state    <= S_FETCH;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_init_seq.sv
// tb/tb_i2c_init_seq.sv - self-checking bench for i2c_init_seq with a reactive core model
`timescale 1ns/1ps
module tb_i2c_init_seq;

   localparam int AW  = 2;
   localparam int DU  = 10;
   localparam int GAP = 64;
   localparam int TMO = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] tbl_addr;
   logic [17:0]   tbl_data = '0;
   logic          i2c_rqt;
   logic          cmd;
   logic [6:0]    addr_dev;
   logic [7:0]    addr_reg_L;
   logic [7:0]    data_wr_L;
   logic [7:0]    data_rd;
   logic          data_rdy;
   logic          error;
   logic          i2c_done;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_idx;
   logic          mismatch;
   logic [7:0]    rd_last;

   int errors = 0;
   int checks = 0;

   i2c_init_seq #(
      .DEV_ADDR(7'h36), .TBL_AW(AW), .DELAY_UNIT(DU),
      .RQT_HOLD(4), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .i2c_rqt(i2c_rqt), .cmd(cmd), .addr_dev(addr_dev),
      .addr_reg_L(addr_reg_L), .data_wr_L(data_wr_L), .data_rd(data_rd),
      .data_rdy(data_rdy), .error(error), .i2c_done(i2c_done), .busy(busy),
      .done(done), .fail(fail), .fail_idx(fail_idx), .mismatch(mismatch),
      .rd_last(rd_last)
   );

   always #5 clk = ~clk;

   // Register table ROM with one cycle of read latency.
   logic [17:0] tbl [4];
   always @(posedge clk) tbl_data <= tbl[tbl_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: logs each request, answers after a random latency.
   int          nack_at = -1;
   bit          never_done = 1'b0;
   logic [7:0]  rd_value = 8'h00;
   int          base = 0;
   int          log_n = 0;
   logic        log_cmd [512];
   logic [7:0]  log_reg [512];
   logic [7:0]  log_val [512];
   int          log_rise [512];
   int          log_fall [512];
   int          m_st;
   int          m_cnt;
   logic        m_nack;
   logic        m_rd;
   logic        rqt_q;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; m_cnt <= 0; m_nack <= 1'b0; m_rd <= 1'b0; rqt_q <= 1'b0;
         i2c_done <= 1'b0; data_rdy <= 1'b0; error <= 1'b0; data_rd <= 8'h00;
      end else begin
         rqt_q    <= i2c_rqt;
         data_rdy <= 1'b0;
         case (m_st)
            0: if (i2c_rqt && !rqt_q) begin
                  log_cmd[log_n]  <= cmd;
                  log_reg[log_n]  <= addr_reg_L;
                  log_val[log_n]  <= data_wr_L;
                  log_rise[log_n] <= cyc;
                  log_n  <= log_n + 1;
                  m_nack <= ((log_n - base) == nack_at);
                  m_rd   <= !cmd;
                  m_cnt  <= $urandom_range(20, 6);
                  m_st   <= never_done ? 3 : 1;
               end
            1: if (m_cnt == 0) begin
                  i2c_done <= 1'b1;
                  if (m_nack) error <= 1'b1;
                  m_cnt <= $urandom_range(15, 3);
                  m_st  <= 2;
               end else begin
                  if (m_cnt == 1 && m_rd && !m_nack) begin
                     data_rdy <= 1'b1;
                     data_rd  <= rd_value;
                  end
                  m_cnt <= m_cnt - 1;
               end
            2: if (m_cnt == 0) begin
                  i2c_done <= 1'b0;
                  log_fall[log_n-1] <= cyc;
                  m_st <= 0;
               end else begin
                  m_cnt <= m_cnt - 1;
               end
            default: ;
         endcase
      end
   end

   // Protocol monitors: request fields settled before rqt rises; done/fail exclusive.
   int   stab_bad = 0;
   int   both_bad = 0;
   logic p_rqt = 1'b0;
   logic p_cmd = 1'b1;
   logic [7:0] p_reg = 8'h00;
   logic [7:0] p_val = 8'h00;
   always @(negedge clk) begin
      if (i2c_rqt && !p_rqt && (cmd !== p_cmd || addr_reg_L !== p_reg || data_wr_L !== p_val))
         stab_bad++;
      if (done && fail) both_bad++;
      p_rqt = i2c_rqt; p_cmd = cmd; p_reg = addr_reg_L; p_val = data_wr_L;
   end

   // Reference model: walks the table by the operational rules.
   logic       exp_cmd [4];
   logic [7:0] exp_reg [4];
   logic [7:0] exp_val [4];
   int         exp_n;
   logic       exp_done, exp_fail, exp_mis;
   logic [1:0] exp_fidx, exp_addr;
   logic [7:0] exp_rdl = 8'h00;

   task automatic ref_run(input int nack_idx, input logic [7:0] rdv);
      logic [1:0] op;
      exp_n = 0; exp_done = 0; exp_fail = 0; exp_mis = 0; exp_fidx = 0; exp_addr = 0;
      for (int i = 0; i < 4; i++) begin
         op = tbl[i][17:16];
         if (op == 2'b11) begin exp_done = 1; exp_addr = 2'(i); break; end
         if (op != 2'b10) begin
            exp_cmd[exp_n] = (op == 2'b00);
            exp_reg[exp_n] = tbl[i][15:8];
            exp_val[exp_n] = tbl[i][7:0];
            if (exp_n == nack_idx) begin
               exp_fail = 1; exp_fidx = 2'(i); exp_addr = 2'(i); exp_n++; break;
            end
            exp_n++;
            if (op == 2'b01) begin
               exp_rdl = rdv;
               if (rdv != tbl[i][7:0]) exp_mis = 1;
            end
         end
         if (i == 3) begin exp_done = 1; exp_addr = 2'd3; end
      end
   endtask

   function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] r, input logic [7:0] v);
      return {op, r, v};
   endfunction

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_rdl = 8'h00;
   endtask

   // Pulse start, optionally poke start again at negedge 'poke', wait for idle.
   task automatic run_seq(input int poke, output int lat, output int k_idle);
      int k;
      base = log_n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; k_idle = -1; k = 1;
      while (k <= 4000) begin
         start = (k == poke);
         if (lat < 0 && i2c_rqt) lat = k;
         if (!busy) begin k_idle = k; break; end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      checks++;
      if (k_idle < 0) begin
         errors++;
         $display("FAIL run_timeout: busy still %0b after %0d cycles, required 0", busy, k);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (tbl_addr !== 2'd0 || fail_idx !== 2'd0) begin errors++;
         $display("FAIL reset_addr: tbl_addr=%0d fail_idx=%0d required 0/0", tbl_addr, fail_idx); end
      checks++; if (i2c_rqt !== 1'b0 || cmd !== 1'b1) begin errors++;
         $display("FAIL reset_rqt_cmd: rqt=%0b cmd=%0b required 0/1", i2c_rqt, cmd); end
      checks++; if (addr_dev !== 7'h36) begin errors++;
         $display("FAIL reset_addr_dev: got %h required 36", addr_dev); end
      checks++; if (addr_reg_L !== 8'h00 || data_wr_L !== 8'h00 || rd_last !== 8'h00) begin errors++;
         $display("FAIL reset_data: reg=%h wr=%h rd_last=%h required 00", addr_reg_L, data_wr_L, rd_last); end
      checks++; if ({busy, done, fail, mismatch} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags: busy/done/fail/mis=%b required 0000", {busy, done, fail, mismatch}); end
   endtask

   task automatic test_writes();
      int lat, ki;
      tbl[0] = ent(2'b00, 8'h10, 8'hA5);
      tbl[1] = ent(2'b00, 8'h11, 8'h5A);
      tbl[2] = ent(2'b11, 8'h00, 8'h00);
      tbl[3] = ent(2'b00, 8'($urandom), 8'($urandom));
      run_seq(20, lat, ki);   // second start arrives mid-transaction and must be ignored
      checks++; if (lat !== 3) begin errors++;
         $display("FAIL start_to_rqt: latency %0d required 3", lat); end
      checks++; if (log_n - base !== 2) begin errors++;
         $display("FAIL wr_count: %0d requests required 2", log_n - base); end
      checks++; if (log_cmd[base] !== 1'b1 || log_reg[base] !== 8'h10 || log_val[base] !== 8'hA5) begin errors++;
         $display("FAIL wr_req0: cmd=%0b reg=%h val=%h required 1/10/A5", log_cmd[base], log_reg[base], log_val[base]); end
      checks++; if (log_cmd[base+1] !== 1'b1 || log_reg[base+1] !== 8'h11 || log_val[base+1] !== 8'h5A) begin errors++;
         $display("FAIL wr_req1: cmd=%0b reg=%h val=%h required 1/11/5A", log_cmd[base+1], log_reg[base+1], log_val[base+1]); end
      checks++; if (done !== 1'b1 || fail !== 1'b0 || tbl_addr !== 2'd2) begin errors++;
         $display("FAIL wr_end: done=%0b fail=%0b tbl_addr=%0d required 1/0/2", done, fail, tbl_addr); end
      checks++; if (stab_bad !== 0) begin errors++;
         $display("FAIL fields_stable: %0d unstable request rises required 0", stab_bad); end
   endtask

   task automatic test_read();
      int lat, ki;
      logic [7:0] v, r;
      logic [7:0] rv [2];
      rv[0] = 8'h3C; rv[1] = 8'h3D;
      tbl[0] = ent(2'b01, 8'h20, 8'h3C);
      tbl[1] = ent(2'b11, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
         rd_value = rv[i];
         run_seq(0, lat, ki);
         checks++; if (mismatch !== (i == 1) || rd_last !== rv[i] || done !== 1'b1) begin errors++;
            $display("FAIL read_%0d: mis=%0b rd_last=%h done=%0b required %0b/%h/1", i, mismatch, rd_last, done, i == 1, rv[i]); end
         checks++; if (log_n - base !== 1 || log_cmd[base] !== 1'b0 || log_reg[base] !== 8'h20) begin errors++;
            $display("FAIL read_req_%0d: n=%0d cmd=%0b reg=%h required 1/0/20", i, log_n - base, log_cmd[base], log_reg[base]); end
      end
      for (int i = 0; i < 3; i++) begin
         v = 8'($urandom); r = 8'($urandom);
         tbl[0] = ent(2'b01, r, v);
         rd_value = ($urandom_range(1, 0) == 1) ? v : v ^ 8'($urandom_range(255, 1));
         run_seq(0, lat, ki);
         checks++; if (mismatch !== (rd_value != v) || rd_last !== rd_value) begin errors++;
            $display("FAIL read_rand: mis=%0b rd_last=%h required %0b/%h", mismatch, rd_last, rd_value != v, rd_value); end
      end
   endtask

   task automatic test_delay();
      int lat, ki, n, diff, lo;
      for (int i = 0; i < 3; i++) begin
         n = (i == 0) ? 2 : $urandom_range(3, 0);
         tbl[0] = ent(2'b00, 8'($urandom), 8'($urandom));
         tbl[1] = ent(2'b10, 8'($urandom), 8'(n));
         tbl[2] = ent(2'b00, 8'($urandom), 8'($urandom));
         tbl[3] = ent(2'b11, 8'h00, 8'h00);
         run_seq(0, lat, ki);
         checks++; if (log_n - base !== 2 || done !== 1'b1) begin errors++;
            $display("FAIL delay_run: n=%0d done=%0b required 2/1", log_n - base, done); end
         // Gap plus the delay window plus the fixed per-state hops between them.
         diff = log_rise[base+1] - log_fall[base];
         lo = GAP + n * DU + 1;
         checks++; if (diff < lo + 1 || diff > lo + 10) begin errors++;
            $display("FAIL delay_gap: N=%0d spacing %0d required %0d..%0d", n, diff, lo + 1, lo + 10); end
      end
   endtask

   task automatic test_nack();
      int lat, ki;
      for (int i = 0; i < 3; i++) tbl[i] = ent(2'b00, 8'($urandom), 8'($urandom));
      tbl[3] = ent(2'b11, 8'h00, 8'h00);
      nack_at = 1;
      run_seq(0, lat, ki);
      repeat (200) @(negedge clk);
      checks++; if (fail !== 1'b1 || done !== 1'b0 || fail_idx !== 2'd1 || busy !== 1'b0) begin errors++;
         $display("FAIL nack_flags: fail=%0b done=%0b idx=%0d busy=%0b required 1/0/1/0", fail, done, fail_idx, busy); end
      checks++; if (log_n - base !== 2) begin errors++;
         $display("FAIL nack_count: %0d requests required 2", log_n - base); end
      nack_at = -1;
      do_reset();
   endtask

   task automatic test_timeout();
      int lat, ki;
      tbl[0] = ent(2'b00, 8'h44, 8'h55);
      tbl[1] = ent(2'b11, 8'h00, 8'h00);
      never_done = 1'b1;
      run_seq(0, lat, ki);
      checks++; if (ki - lat < TMO - 1 || ki - lat > TMO + 3) begin errors++;
         $display("FAIL timeout_time: fail after %0d cycles required %0d..%0d", ki - lat, TMO - 1, TMO + 3); end
      checks++; if (fail !== 1'b1 || done !== 1'b0 || fail_idx !== 2'd0) begin errors++;
         $display("FAIL timeout_flags: fail=%0b done=%0b idx=%0d required 1/0/0", fail, done, fail_idx); end
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (busy !== 1'b1 || i2c_rqt !== 1'b0 || fail !== 1'b0) begin errors++;
         $display("FAIL rerun_wait: busy=%0b rqt=%0b fail=%0b required 1/0/0", busy, i2c_rqt, fail); end
      rst_n = 1'b0;
      #1;
      checks++; if ({i2c_rqt, busy, done, fail, mismatch} !== 5'b00000 || cmd !== 1'b1) begin errors++;
         $display("FAIL midreset_flags: rqt/busy/done/fail/mis=%b cmd=%0b required 00000/1", {i2c_rqt, busy, done, fail, mismatch}, cmd); end
      checks++; if (tbl_addr !== 2'd0 || addr_reg_L !== 8'h00 || data_wr_L !== 8'h00 || rd_last !== 8'h00) begin errors++;
         $display("FAIL midreset_data: addr=%0d reg=%h wr=%h rd=%h required 0/00/00/00", tbl_addr, addr_reg_L, data_wr_L, rd_last); end
      never_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_rdl = 8'h00;
   endtask

   task automatic test_no_end();
      int lat, ki;
      for (int i = 0; i < 4; i++) tbl[i] = ent(2'b00, 8'($urandom), 8'($urandom));
      run_seq(0, lat, ki);
      checks++; if (log_n - base !== 4) begin errors++;
         $display("FAIL noend_count: %0d requests required 4", log_n - base); end
      checks++; if (done !== 1'b1 || fail !== 1'b0 || tbl_addr !== 2'd3) begin errors++;
         $display("FAIL noend_flags: done=%0b fail=%0b tbl_addr=%0d required 1/0/3", done, fail, tbl_addr); end
      checks++; if (log_reg[base+3] !== tbl[3][15:8] || log_val[base+3] !== tbl[3][7:0]) begin errors++;
         $display("FAIL noend_last: reg=%h val=%h required %h/%h", log_reg[base+3], log_val[base+3], tbl[3][15:8], tbl[3][7:0]); end
   endtask

   task automatic test_random();
      int lat, ki, pick, bad;
      logic [1:0] op;
      for (int it = 0; it < 12; it++) begin
         pick = -1;
         for (int i = 0; i < 4; i++) begin
            op = 2'($urandom_range(3, 0));
            if (op == 2'b11 && $urandom_range(1, 0) == 1) op = 2'b01;
            tbl[i] = ent(op, 8'($urandom), (op == 2'b10) ? 8'($urandom_range(3, 0)) : 8'($urandom));
            if (op == 2'b01 && pick < 0) pick = i;
         end
         rd_value = (pick >= 0 && $urandom_range(1, 0) == 1) ? tbl[pick][7:0] : 8'($urandom);
         nack_at = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : -1;
         ref_run(nack_at, rd_value);
         run_seq(0, lat, ki);
         bad = 0;
         for (int i = 0; i < exp_n && i < log_n - base; i++)
            if (log_cmd[base+i] !== exp_cmd[i] || log_reg[base+i] !== exp_reg[i] || log_val[base+i] !== exp_val[i]) bad++;
         checks++; if (log_n - base !== exp_n || bad != 0) begin errors++;
            $display("FAIL rand_reqs[%0d]: n=%0d bad=%0d required n=%0d bad=0", it, log_n - base, bad, exp_n); end
         checks++; if (done !== exp_done || fail !== exp_fail || tbl_addr !== exp_addr) begin errors++;
            $display("FAIL rand_end[%0d]: done=%0b fail=%0b addr=%0d required %0b/%0b/%0d", it, done, fail, tbl_addr, exp_done, exp_fail, exp_addr); end
         checks++; if (fail_idx !== exp_fidx || mismatch !== exp_mis || rd_last !== exp_rdl) begin errors++;
            $display("FAIL rand_status[%0d]: idx=%0d mis=%0b rd=%h required %0d/%0b/%h", it, fail_idx, mismatch, rd_last, exp_fidx, exp_mis, exp_rdl); end
         if (exp_fail) begin
            nack_at = -1;
            do_reset();
         end
      end
      nack_at = -1;
      checks++; if (both_bad !== 0 || stab_bad !== 0) begin errors++;
         $display("FAIL monitors: both_set=%0d unstable=%0d required 0/0", both_bad, stab_bad); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tbl[i] = ent(2'b11, 8'h00, 8'h00);
      test_reset();
      test_writes();
      test_read();
      test_delay();
      test_nack();
      test_timeout();
      test_no_end();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
